// File: rtl/wb_pkg.sv
// Shared definitions for the wishbone master bridge: FSM encoding and default sizes.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam int WB_AW              = 32;
    localparam int WB_DW              = 32;
    localparam int WB_TIMEOUT_CYCLES  = 255;

endpackage

// File: rtl/wb_master_timer.sv
// 16-bit bus-cycle counter for the wishbone master watchdog.
// Flags the LIMIT-th consecutive enabled cycle since the last clear.
module wb_master_timer #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [15:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Terminal one cycle early so the abort lands on the LIMIT-th waiting edge.
    assign o_tc = i_enable && (r_count == 16'(LIMIT - 1));

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic single-transfer master driven by a valid/ready command stream.
// Optional bus watchdog compiled in with WB_MASTER_TIMEOUT_EN.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int AW             = WB_AW,
    parameter int DW             = WB_DW,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
    localparam int SW            = DW / 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [DW-1:0] cmd_dat_i,
    input  logic [SW-1:0] cmd_sel_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_dat_o,
    output logic          rsp_err_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [SW-1:0] wbm_sel_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    output logic          busy_o
);

    // Out-of-range parameters leave this named block in the elaborated hierarchy.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_invalid
    end

    wb_state_t   r_state, w_state_nxt;
    logic        r_cmd_ready, w_cmd_ready_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0] r_rsp_dat, w_rsp_dat_nxt;
    logic        r_rsp_err, w_rsp_err_nxt;
    logic        r_cyc, w_cyc_nxt;
    logic        r_stb, w_stb_nxt;
    logic        r_we, w_we_nxt;
    logic [SW-1:0] r_sel, w_sel_nxt;
    logic [AW-1:0] r_adr, w_adr_nxt;
    logic [DW-1:0] r_dat, w_dat_nxt;
    logic        r_busy;

    logic w_accept;
    logic w_timeout;

    assign w_accept = (r_state == IDLE) && cmd_valid_i && r_cmd_ready;

`ifdef WB_MASTER_TIMEOUT_EN
    logic w_tc;

    wb_master_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_clear (w_accept),
        .i_enable((r_state == BUS) && !wbm_ack_i && !wbm_err_i),
        .o_tc    (w_tc)
    );

    assign w_timeout = w_tc;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cyc       <= w_cyc_nxt;
            r_stb       <= w_stb_nxt;
            r_we        <= w_we_nxt;
            r_sel       <= w_sel_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // Next-state and next-output values; every register holds unless its state moves it.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;
        w_cyc_nxt       = r_cyc;
        w_stb_nxt       = r_stb;
        w_we_nxt        = r_we;
        w_sel_nxt       = r_sel;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;

        case (r_state)
            IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_we_nxt        = cmd_we_i;
                    w_adr_nxt       = cmd_adr_i;
                    w_dat_nxt       = cmd_dat_i;
                    w_sel_nxt       = cmd_sel_i;
                    w_cyc_nxt       = 1'b1;
                    w_stb_nxt       = 1'b1;
                    w_cmd_ready_nxt = 1'b0;
                    w_state_nxt     = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i || wbm_err_i || w_timeout) begin
                    w_cyc_nxt       = 1'b0;
                    w_stb_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = wbm_err_i || w_timeout;
                    // Error wins over a simultaneous ack, so data only passes on a clean read ack.
                    w_rsp_dat_nxt   = (wbm_ack_i && !wbm_err_i && !r_we) ? wbm_dat_i : '0;
                    w_state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed self-checking bench for wb_master_bridge; timeout scenario runs when
// WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic [SW-1:0] cmd_sel_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;
    logic          busy_o;

    int testsRun    = 0;
    int testsFailed = 0;

    logic          tWe [4];
    logic [AW-1:0] tAdr[4];
    logic [DW-1:0] tDat[4];
    logic [SW-1:0] tSel[4];

    wb_master_bridge #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_adr_i  (cmd_adr_i),
        .cmd_dat_i  (cmd_dat_i),
        .cmd_sel_i  (cmd_sel_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .busy_o     (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Advance to just after the next rising edge, where outputs are settled.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] adr,
                                 input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        tick();
        testsRun++;
        if ({cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, busy_o, rsp_err_o} !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl got=%b want=000000",
                     {cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, busy_o, rsp_err_o});
        end
        testsRun++;
        if ({wbm_adr_o, wbm_dat_o, rsp_dat_o} !== 96'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data adr=%h dat=%h rsp=%h want all 0", wbm_adr_o, wbm_dat_o, rsp_dat_o);
        end
        wb_rst_i = 1'b0;
        tick();
        testsRun++;
        if (cmd_ready_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready got=%b want=1", cmd_ready_o);
        end
    endtask

    task automatic test_write();
        applyStimulus(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            testsRun++;
            if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready_o, busy_o} !==
                {3'b111, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1'b0, 1'b1}) begin
                testsFailed++;
                $display("[TB] FAIL write_bus[%0d] cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rdy=%b busy=%b want 1 1 1 30000004 a5a51234 f 0 1",
                         i, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready_o, busy_o);
            end
            if (i == 1) wbm_ack_i = 1'b1;
            else tick();
        end
        wbm_dat_i = 32'h5555_AAAA;
        tick();
        wbm_ack_i = 1'b0;
        testsRun++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid_o, rsp_err_o, rsp_dat_o, cmd_ready_o} !== {4'b0010, 32'h0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL write_rsp cyc=%b stb=%b vld=%b err=%b dat=%h rdy=%b want 0 0 1 0 00000000 0",
                     wbm_cyc_o, wbm_stb_o, rsp_valid_o, rsp_err_o, rsp_dat_o, cmd_ready_o);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        testsRun++;
        if ({rsp_valid_o, cmd_ready_o, busy_o} !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL write_done vld/rdy/busy got=%b want=010", {rsp_valid_o, cmd_ready_o, busy_o});
        end
    endtask

    task automatic test_read();
        applyStimulus(1'b0, 32'h3000_0010, 32'h1111_2222, 4'h3);
        tick();
        cmd_valid_i = 1'b0;
        testsRun++;
        if ({wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== {2'b10, 4'h3, 32'h3000_0010, 32'h1111_2222}) begin
            testsFailed++;
            $display("[TB] FAIL read_bus stb=%b we=%b sel=%h adr=%h dat=%h want 1 0 3 30000010 11112222",
                     wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
        end
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            testsRun++;
            if ({rsp_valid_o, rsp_err_o, rsp_dat_o, cmd_ready_o, wbm_cyc_o} !== {2'b10, 32'hDEAD_BEEF, 2'b00}) begin
                testsFailed++;
                $display("[TB] FAIL read_hold[%0d] vld=%b err=%b dat=%h rdy=%b cyc=%b want 1 0 deadbeef 0 0",
                         i, rsp_valid_o, rsp_err_o, rsp_dat_o, cmd_ready_o, wbm_cyc_o);
            end
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        testsRun++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL read_done vld/rdy got=%b want=01", {rsp_valid_o, cmd_ready_o});
        end
    endtask

    task automatic test_error();
        applyStimulus(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        testsRun++;
        if ({rsp_valid_o, rsp_err_o, rsp_dat_o} !== {2'b11, 32'h0}) begin
            testsFailed++;
            $display("[TB] FAIL error_rsp vld=%b err=%b dat=%h want 1 1 00000000", rsp_valid_o, rsp_err_o, rsp_dat_o);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        wbm_ack_i = 1'b1;
        tick();
        tick();
        wbm_ack_i = 1'b0;
        testsRun++;
        if ({wbm_cyc_o, rsp_valid_o, cmd_ready_o, busy_o} !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL spurious_ack cyc/vld/rdy/busy got=%b want=0010",
                     {wbm_cyc_o, rsp_valid_o, cmd_ready_o, busy_o});
        end
    endtask

    task automatic test_reset_mid_bus();
        applyStimulus(1'b1, 32'h3000_0030, 32'hFEED_0001, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        testsRun++;
        if ({wbm_cyc_o, wbm_stb_o} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL midbus_start cyc/stb got=%b want=11", {wbm_cyc_o, wbm_stb_o});
        end
        #2 wb_rst_i = 1'b1;
        #1;
        testsRun++;
        if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL midbus_async cyc/stb got=%b want=00", {wbm_cyc_o, wbm_stb_o});
        end
        tick();
        wb_rst_i = 1'b0;
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        testsRun++;
        if ({rsp_valid_o, cmd_ready_o, wbm_cyc_o} !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL midbus_after vld/rdy/cyc got=%b want=010", {rsp_valid_o, cmd_ready_o, wbm_cyc_o});
        end
        applyStimulus(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0BAD_F00D;
        tick();
        wbm_ack_i = 1'b0;
        testsRun++;
        if ({rsp_valid_o, rsp_err_o, rsp_dat_o} !== {2'b10, 32'h0BAD_F00D}) begin
            testsFailed++;
            $display("[TB] FAIL midbus_next vld=%b err=%b dat=%h want 1 0 0badf00d", rsp_valid_o, rsp_err_o, rsp_dat_o);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(1'b0, 32'h3000_0050, 32'h0, 4'hF);
            tick();
            cmd_valid_i = 1'b0;
            for (int i = 1; i < 8; i++) tick();
            testsRun++;
            if (wbm_cyc_o !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL timeout_wait[%0d] cyc got=%b want=1", rep, wbm_cyc_o);
            end
            if (rep == 1) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'hCAFE_F00D;
            end
            tick();
            wbm_ack_i = 1'b0;
            testsRun++;
            if ({wbm_cyc_o, rsp_valid_o, rsp_err_o, rsp_dat_o} !==
                ((rep == 0) ? {3'b011, 32'h0} : {3'b010, 32'hCAFE_F00D})) begin
                testsFailed++;
                $display("[TB] FAIL timeout_end[%0d] cyc=%b vld=%b err=%b dat=%h", rep,
                         wbm_cyc_o, rsp_valid_o, rsp_err_o, rsp_dat_o);
            end
            rsp_ready_i = 1'b1;
            tick();
            rsp_ready_i = 1'b0;
        end
    endtask
`endif

    task automatic test_back_to_back();
        int accIdx = 0;
        int rspIdx = 0;
        int busIdx = 0;
        logic prevCyc = 1'b0;
        logic doAcc;
        logic doRsp;
        logic [DW-1:0] expDat;
        tWe[0] = 1'b1; tAdr[0] = 32'h3000_0100; tDat[0] = 32'h0102_0304; tSel[0] = 4'hF;
        tWe[1] = 1'b0; tAdr[1] = 32'h3000_0104; tDat[1] = 32'h0;         tSel[1] = 4'hF;
        tWe[2] = 1'b0; tAdr[2] = 32'h3000_0108; tDat[2] = 32'h0;         tSel[2] = 4'h1;
        tWe[3] = 1'b1; tAdr[3] = 32'h3000_010C; tDat[3] = 32'hAABB_CCDD; tSel[3] = 4'hC;
        applyStimulus(tWe[0], tAdr[0], tDat[0], tSel[0]);
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 60 && rspIdx < 4; c++) begin
            if (wbm_cyc_o && !prevCyc && busIdx < 4) begin
                testsRun++;
                if ({wbm_we_o, wbm_adr_o, wbm_sel_o} !== {tWe[busIdx], tAdr[busIdx], tSel[busIdx]}) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_bus[%0d] we=%b adr=%h sel=%h want %b %h %h", busIdx,
                             wbm_we_o, wbm_adr_o, wbm_sel_o, tWe[busIdx], tAdr[busIdx], tSel[busIdx]);
                end
                busIdx++;
            end
            prevCyc = wbm_cyc_o;
            testsRun++;
            if (wbm_cyc_o && (cmd_ready_o || rsp_valid_o)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_overlap cyc=%b rdy=%b vld=%b want cyc exclusive", wbm_cyc_o, cmd_ready_o, rsp_valid_o);
            end
            wbm_ack_i = wbm_stb_o;
            wbm_dat_i = wbm_adr_o ^ 32'h5A5A_0000;
            doAcc = cmd_valid_i && cmd_ready_o;
            doRsp = rsp_valid_o && rsp_ready_i;
            if (doRsp) begin
                expDat = tWe[rspIdx] ? 32'h0 : (tAdr[rspIdx] ^ 32'h5A5A_0000);
                testsRun++;
                if ({rsp_err_o, rsp_dat_o} !== {1'b0, expDat}) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_rsp[%0d] err=%b dat=%h want 0 %h", rspIdx, rsp_err_o, rsp_dat_o, expDat);
                end
                rspIdx++;
            end
            tick();
            if (doAcc) begin
                accIdx++;
                if (accIdx < 4) applyStimulus(tWe[accIdx], tAdr[accIdx], tDat[accIdx], tSel[accIdx]);
                else cmd_valid_i = 1'b0;
            end
        end
        wbm_ack_i = 1'b0;
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        testsRun++;
        if (rspIdx != 4 || busIdx != 4) begin
            testsFailed++;
            $display("[TB] FAIL b2b_count responses=%0d bus_cycles=%0d want 4 4", rspIdx, busIdx);
        end
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_dat_i   = '0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_error();
        test_reset_mid_bus();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone classic (B4, non-pipelined) single-transfer master. It is the initiator end of the wishbone slave port presented on the user project wrapper.
- Converts a valid/ready command stream into one bus cycle per command and returns a data/error response on a valid/ready response stream.
- Sits between a command source (core load/store unit or LA-driven debug port) and the user-area wishbone interconnect.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8. SW = DW/8.
- TIMEOUT_CYCLES, 255, max cycles with stb high before abort; used only when the optional feature is compiled in; range 1..65535.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  AW  byte address
- cmd_dat_i  in  DW  write data
- cmd_sel_i  in  SW  byte enables
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  DW  read data (0 for writes)
- rsp_err_o  out  1  bus error or timeout
- wbm_cyc_o  out  1  wishbone cycle
- wbm_stb_o  out  1  wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  SW  byte select
- wbm_adr_o  out  AW  address
- wbm_dat_o  out  DW  write data
- wbm_dat_i  in  DW  read data
- wbm_ack_i  in  1  transfer acknowledge
- wbm_err_i  in  1  transfer error
- busy_o  out  1  high in BUS or RESP

Behaviour:
- All outputs are registered.
- Reset (async, wb_rst_i=1) forces state IDLE and drives every output to 0, except cmd_ready_o, which is 1 once reset deasserts.
- FSM states: IDLE, BUS, RESP.

IDLE
- cmd_ready_o=1.
- On cmd_valid_i&cmd_ready_o at edge N: latch we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, clear cmd_ready_o, go to BUS.
- wbm_ack_i and wbm_err_i are ignored in IDLE.

BUS
- cyc, stb, adr, we, sel and dat are held stable until termination.
- Termination is the first edge where wbm_ack_i or wbm_err_i is sampled high. At that edge:
  - cyc=stb=0
  - rsp_dat_o = wbm_dat_i for reads, 0 for writes
  - rsp_err_o = wbm_err_i
  - rsp_valid_o=1
  - go to RESP
- Ack and err high together: err wins; rsp_err_o=1, rsp_dat_o=0.
- Minimum latency: command accepted at edge N, earliest slave ack sampled at edge N+1, rsp_valid_o high after N+1.

RESP
- rsp_valid_o and rsp_dat_o/rsp_err_o are held until rsp_valid_o&rsp_ready_i.
- At that edge: rsp_valid_o=0, cmd_ready_o=1, go to IDLE.
- No new command is accepted while RESP is pending; there is no bypass. Throughput is at most one transfer per 3 cycles.

General rules
- cmd_ready_o=0 in BUS and RESP.
- Reset mid-BUS: cyc/stb drop immediately (asynchronously); the in-flight transfer is lost and no response is produced.
- wbm_dat_o is driven for reads too (latched cmd_dat_i); slaves ignore it.

Optional Feature:
- Macro WB_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without termination.
  - When the count reaches TIMEOUT_CYCLES with no ack/err: cyc=stb=0, rsp_err_o=1, rsp_dat_o=0, go to RESP.
  - An ack arriving on the same edge as the timeout takes priority (normal completion).
  - A late ack arriving in RESP or IDLE is ignored.
- Undefined:
  - No counter is built; BUS waits indefinitely.
  - rsp_err_o comes only from wbm_err_i.

Decomposition:
- Shared package wb_pkg holds:
  - state encoding localparams: IDLE=2'd0, BUS=2'd1, RESP=2'd2
  - default widths AW/DW
  - default TIMEOUT_CYCLES
- Sub-module wb_master_timer (16-bit clear/enable/terminal-count counter): instantiated only under WB_MASTER_TIMEOUT_EN. Otherwise the design is a single module.

Test Plan:
- Write: cmd we=1 adr=0x3000_0004 dat=0xA5A5_1234 sel=0xF; slave acks 2 cycles after stb.
  -> wbm_adr_o/dat_o/sel_o match and stay stable while stb is high; rsp_valid_o with rsp_err_o=0, rsp_dat_o=0; cmd_ready_o low throughout.
- Read: cmd adr=0x3000_0010 sel=0x3; slave returns 0xDEAD_BEEF with 0-wait ack.
  -> rsp_valid_o one cycle after ack is sampled, rsp_dat_o=0xDEAD_BEEF; rsp_ready_i held low 5 cycles -> response held stable, cmd_ready_o=0.
- Error: slave asserts err and ack together.
  -> rsp_err_o=1, rsp_dat_o=0; a spurious ack in IDLE afterwards causes no state change.
- Reset mid-BUS: assert wb_rst_i while stb is high.
  -> cyc/stb go 0 asynchronously before the next edge; no rsp_valid_o; after release, cmd_ready_o=1 and the next command completes normally.
- With WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks.
  -> cyc drops after 8 BUS cycles, rsp_err_o=1; a repeat where ack arrives on cycle 8 completes without error.
- Back-to-back: 4 queued commands with rsp_ready_i=1.
  -> 4 responses in order; one bus cycle per command; cyc never overlaps between transfers.
